// File: rtl/ioctl_pkg.sv
// ioctl_pkg
//   Shared definitions for the ioctl download source: the default address
//   width, the transfer state encoding, well-known file indices and a small
//   helper used to size the shared cycle counter.
package ioctl_pkg;

    localparam int IOCTL_ADDR_W = 25;

    localparam logic [7:0] IDX_ROM = 8'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ISSUE = 3'd2,
        GAP   = 3'd3,
        TAIL  = 3'd4
    } ioctl_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ioctl_byte_fifo.sv
// ioctl_byte_fifo
//   Synchronous byte FIFO with show-ahead head output and a synchronous flush.
//   Ports:
//     clk, reset   clock and asynchronous active-high reset
//     push, din    write request and byte (ignored while full or flushing)
//     pop          remove the head byte (ignored while empty or flushing)
//     flush        discard all contents this cycle
//     head         byte at the front of the queue, valid while !empty
//     empty        no bytes stored
//     ready        registered "space available"; low while in reset
module ioctl_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    input  logic       flush,
    output logic [7:0] head,
    output logic       empty,
    output logic       ready
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [7:0]     mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] fill_d;
    logic           ready_q, ready_d;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign ready = ready_q;

    // ready is computed from the next occupancy so it is registered yet
    // still exact on the cycle the FIFO becomes full or frees a slot.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        fill_d  = wr_ptr_d - rd_ptr_d;
        ready_d = (fill_d != (PTR_W + 1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/ioctl_dl_source.sv
// ioctl_dl_source
//   Transmit side of the ioctl download protocol (HPS role). Buffers an input
//   byte stream and, after a start request, drives a paced sequence of
//   one-cycle ioctl_wr strobes inside an ioctl_download window, honouring the
//   receiver's ioctl_wait backpressure.
//   Ports:
//     clk, reset                      clock, asynchronous active-high reset
//     start, index, length            begin a transfer (sampled in IDLE only)
//     abort                           terminate an active transfer
//     s_valid, s_data, s_ready        input byte stream
//     ioctl_wait                      receiver backpressure
//     ioctl_download, ioctl_index     transfer window and latched file index
//     ioctl_wr, ioctl_addr, ioctl_dout write strobe, address and data
//     busy, done, count               status: active, end pulse, bytes written
//   Parameters: SETUP_CYC, WR_GAP and TAIL_CYC must each be at least 1.
module ioctl_dl_source
    import ioctl_pkg::*;
#(
    parameter int ADDR_W     = IOCTL_ADDR_W,
    parameter int FIFO_DEPTH = 16,
    parameter int SETUP_CYC  = 4,
    parameter int WR_GAP     = 2,
    parameter int TAIL_CYC   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              ioctl_wait,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

    localparam int CYC_MAX = max3(SETUP_CYC, WR_GAP, TAIL_CYC);
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(SETUP_CYC - 1);
    localparam logic [CYC_W-1:0] GAP_LAST   = CYC_W'(WR_GAP - 1);
    localparam logic [CYC_W-1:0] TAIL_LAST  = CYC_W'(TAIL_CYC - 1);

    ioctl_state_e      state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [ADDR_W-1:0] length_q, length_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        index_q, index_d;
    logic [7:0]        dout_q, dout_d;
    logic              download_q, download_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_empty;
    logic [7:0]        fifo_head;

    assign fifo_push = s_valid && s_ready;

    ioctl_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (s_data),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .head  (fifo_head),
        .empty (fifo_empty),
        .ready (s_ready)
    );

    // Next-state logic. An abort in any active state takes priority over the
    // normal sequence, so a write that would have issued in the same cycle is
    // dropped and its byte is flushed along with the rest of the buffer.
    // A new start also flushes, discarding bytes left over from a previous
    // transfer that supplied more data than its length.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        length_d   = length_q;
        count_d    = count_q;
        addr_d     = addr_q;
        index_d    = index_q;
        dout_d     = dout_q;
        download_d = download_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d    = IDLE;
            cyc_d      = '0;
            download_d = 1'b0;
            done_d     = 1'b1;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        index_d    = index;
                        length_d   = length;
                        count_d    = '0;
                        addr_d     = '0;
                        download_d = 1'b1;
                        cyc_d      = '0;
                        fifo_flush = 1'b1;
                        state_d    = SETUP;
                    end
                end
                SETUP: begin
                    if (cyc_q == SETUP_LAST) begin
                        cyc_d   = '0;
                        state_d = (length_q == '0) ? TAIL : ISSUE;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                ISSUE: begin
                    if (!fifo_empty && !ioctl_wait) begin
                        wr_d     = 1'b1;
                        dout_d   = fifo_head;
                        addr_d   = count_q;
                        count_d  = count_q + ADDR_W'(1);
                        fifo_pop = 1'b1;
                        cyc_d    = '0;
                        state_d  = GAP;
                    end
                end
                GAP: begin
                    if (cyc_q == GAP_LAST) begin
                        cyc_d   = '0;
                        state_d = (count_q < length_q) ? ISSUE : TAIL;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                TAIL: begin
                    if (cyc_q == TAIL_LAST) begin
                        cyc_d      = '0;
                        download_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    cyc_d      = '0;
                    download_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset clears everything at once, which
    // drops download and wr mid-transfer without producing a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            length_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            index_q    <= '0;
            dout_q     <= '0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            length_q   <= length_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            index_q    <= index_d;
            dout_q     <= dout_d;
            download_q <= download_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign ioctl_download = download_q;
    assign ioctl_index    = index_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign count          = count_q;

endmodule

// File: tb/tb_ioctl_dl_source.sv
// tb_ioctl_dl_source
//   Self-checking bench for ioctl_dl_source. A feeder process streams bytes
//   from txQ, a reference queue tracks which bytes the source must emit, and a
//   monitor checks every write strobe against that queue and against the
//   timing rules of the protocol. The main process runs directed scenarios
//   followed by randomized transfers.
module tb_ioctl_dl_source;

    localparam int ADDR_W     = 25;
    localparam int FIFO_DEPTH = 16;
    localparam int SETUP_CYC  = 4;
    localparam int WR_GAP     = 2;
    localparam int TAIL_CYC   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        index = 8'd0;
    logic [ADDR_W-1:0] length = '0;
    logic              abort = 1'b0;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              ioctl_wait = 1'b0;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  modelQ[$];
    logic [7:0]  txQ[$];
    logic [7:0]  sentQ[$];
    int          expAddr = 0;
    int          expLen = 0;
    bit          busyExpected = 1'b0;
    logic        waitAtEdge = 1'b0;
    int          validPct = 100;
    int          wrCount = 0;
    int          doneCount = 0;
    int          dlRise = -1;
    int          dlFall = -1;
    int          doneCyc = -1;
    int          lastWrCyc = -1;
    int          wrCycQ[$];
    logic        prevDl = 1'b0;
    logic [31:0] expByte;

    ioctl_dl_source #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SETUP_CYC  (SETUP_CYC),
        .WR_GAP     (WR_GAP),
        .TAIL_CYC   (TAIL_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .index          (index),
        .length         (length),
        .abort          (abort),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .ioctl_wait     (ioctl_wait),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .busy           (busy),
        .done           (done),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the bytes the source owes the receiver, in order.
    // A start or an abort of an active transfer empties it; otherwise every
    // accepted input byte joins the back.
    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            waitAtEdge = ioctl_wait;
            if (reset) begin
                modelQ.delete();
            end else if (start && !busyExpected) begin
                modelQ.delete();
                expAddr = 0;
                expLen  = int'(length);
            end else if (abort && busyExpected) begin
                modelQ.delete();
            end else if (s_valid && s_ready) begin
                modelQ.push_back(s_data);
            end
        end
    end

    // Byte feeder: presents txQ with a random valid duty cycle.
    initial begin : feeder
        s_valid = 1'b0;
        s_data  = 8'd0;
        forever begin
            @(posedge clk);
            if (!reset && s_valid && s_ready && txQ.size() > 0) void'(txQ.pop_front());
            #2;
            if (txQ.size() > 0 && $urandom_range(99) < validPct) begin
                s_valid = 1'b1;
                s_data  = txQ[0];
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    // Write and window monitor.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ioctl_download && !prevDl) dlRise = cyc;
                if (!ioctl_download && prevDl) dlFall = cyc;
            end
            prevDl = ioctl_download;
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (ioctl_wr) begin
                if (modelQ.size() > 0) expByte = {24'd0, modelQ.pop_front()};
                else expByte = 32'h100;
                checkOutput("wr_addr", 32'(ioctl_addr), expAddr);
                checkOutput("wr_dout", 32'(ioctl_dout), expByte);
                checkOutput("wr_in_length", 32'(expAddr < expLen), 1);
                checkOutput("wr_wait_low", 32'(waitAtEdge), 0);
                checkOutput("wr_in_window", 32'(ioctl_download), 1);
                if (lastWrCyc >= 0) checkOutput("wr_spacing_min", 32'((cyc - lastWrCyc) >= 1 + WR_GAP), 1);
                lastWrCyc = cyc;
                wrCycQ.push_back(cyc);
                wrCount++;
                expAddr++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int len, input logic [7:0] idx, input bit withAbort, output int startCyc);
        txQ.delete();
        sentQ.delete();
        wrCycQ.delete();
        wrCount   = 0;
        doneCount = 0;
        dlRise    = -1;
        dlFall    = -1;
        doneCyc   = -1;
        lastWrCyc = -1;
        length    = ADDR_W'(len);
        index     = idx;
        start     = 1'b1;
        abort     = withAbort;
        step();
        start        = 1'b0;
        abort        = 1'b0;
        busyExpected = 1'b1;
        startCyc     = cyc;
    endtask

    task automatic loadBytes(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            txQ.push_back(b);
            sentQ.push_back(b);
        end
    endtask

    task automatic waitWr(input int n, input int budget);
        int k = 0;
        while (wrCount < n && k < budget) begin
            step();
            k++;
        end
        checkOutput("wr_reached", 32'(wrCount >= n), 1);
    endtask

    task automatic waitDone(input int budget, input bit randWait);
        int k = 0;
        while (doneCount == 0 && k < budget) begin
            if (randWait) ioctl_wait = ($urandom_range(99) < 30);
            step();
            k++;
        end
        ioctl_wait   = 1'b0;
        busyExpected = 1'b0;
        checkOutput("done_seen", doneCount, 1);
    endtask

    initial begin : main
        int s;
        int w;
        int a;
        int len;
        logic [7:0] idx;

        // Reset state
        #12;
        checkOutput("rst_download", 32'(ioctl_download), 0);
        checkOutput("rst_wr", 32'(ioctl_wr), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_s_ready", 32'(s_ready), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_addr", 32'(ioctl_addr), 0);
        checkOutput("rst_dout", 32'(ioctl_dout), 0);
        checkOutput("rst_index", 32'(ioctl_index), 0);
        step();
        reset = 1'b0;
        step();
        checkOutput("post_rst_s_ready", 32'(s_ready), 1);

        // 1: four bytes, no backpressure, exact timing
        validPct = 100;
        applyStimulus(4, ioctl_pkg::IDX_ROM, 1'b0, s);
        for (int i = 0; i < 4; i++) begin
            txQ.push_back(8'hA0 + 8'(i));
            sentQ.push_back(8'hA0 + 8'(i));
        end
        checkOutput("t1_busy", 32'(busy), 1);
        waitDone(200, 1'b0);
        repeat (3) step();
        checkOutput("t1_dl_rise", dlRise, s);
        checkOutput("t1_wr_count", wrCount, 4);
        if (wrCycQ.size() == 4) begin
            checkOutput("t1_first_wr", wrCycQ[0], s + 1 + SETUP_CYC);
            for (int i = 1; i < 4; i++) checkOutput("t1_spacing", wrCycQ[i] - wrCycQ[i-1], 1 + WR_GAP);
            checkOutput("t1_dl_fall", dlFall, wrCycQ[3] + WR_GAP + TAIL_CYC);
        end
        checkOutput("t1_done_at_fall", doneCyc, dlFall);
        checkOutput("t1_done_once", doneCount, 1);
        checkOutput("t1_count", 32'(count), 4);
        checkOutput("t1_addr_hold", 32'(ioctl_addr), 3);
        checkOutput("t1_dout_hold", 32'(ioctl_dout), 32'hA3);
        checkOutput("t1_index", 32'(ioctl_index), 32'(ioctl_pkg::IDX_ROM));
        checkOutput("t1_idle", 32'(busy), 0);

        // 2: receiver wait for 10 cycles after the second write
        applyStimulus(4, 8'h11, 1'b0, s);
        loadBytes(4);
        waitWr(2, 100);
        ioctl_wait = 1'b1;
        repeat (10) step();
        checkOutput("t2_stalled", wrCount, 2);
        w = cyc;
        ioctl_wait = 1'b0;
        waitDone(200, 1'b0);
        checkOutput("t2_wr_count", wrCount, 4);
        if (wrCycQ.size() >= 3) checkOutput("t2_third_wr", wrCycQ[2], w + 1);
        checkOutput("t2_count", 32'(count), 4);
        checkOutput("t2_index", 32'(ioctl_index), 32'h11);

        // 3: zero length, with abort asserted alongside start in IDLE
        applyStimulus(0, 8'h22, 1'b1, s);
        checkOutput("t3_start_wins", 32'(busy), 1);
        waitDone(200, 1'b0);
        step();
        checkOutput("t3_no_wr", wrCount, 0);
        checkOutput("t3_dl_rise", dlRise, s);
        checkOutput("t3_dl_fall", dlFall, s + SETUP_CYC + TAIL_CYC);
        checkOutput("t3_done_at_fall", doneCyc, dlFall);
        checkOutput("t3_count", 32'(count), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        checkOutput("t3_idle_abort_ignored", doneCount, 1);
        checkOutput("t3_idle_abort_busy", 32'(busy), 0);

        // 4: starved input after three bytes; a start while busy is ignored
        applyStimulus(8, 8'h33, 1'b0, s);
        loadBytes(3);
        waitWr(3, 100);
        start  = 1'b1;
        length = ADDR_W'(2);
        step();
        start = 1'b0;
        repeat (20) step();
        checkOutput("t4_stall_wr", wrCount, 3);
        checkOutput("t4_stall_busy", 32'(busy), 1);
        checkOutput("t4_stall_addr", 32'(ioctl_addr), 2);
        checkOutput("t4_stall_dout", 32'(ioctl_dout), 32'(sentQ[2]));
        loadBytes(5);
        waitDone(300, 1'b0);
        checkOutput("t4_wr_count", wrCount, 8);
        checkOutput("t4_count", 32'(count), 8);
        checkOutput("t4_addr", 32'(ioctl_addr), 7);
        checkOutput("t4_dout", 32'(ioctl_dout), 32'(sentQ[7]));

        // 5: abort after the second write with a full input buffer
        applyStimulus(40, 8'h44, 1'b0, s);
        loadBytes(30);
        waitWr(2, 100);
        ioctl_wait = 1'b1;
        repeat (20) step();
        checkOutput("t5_full", 32'(s_ready), 0);
        txQ.delete();
        abort = 1'b1;
        step();
        a = cyc;
        abort        = 1'b0;
        ioctl_wait   = 1'b0;
        busyExpected = 1'b0;
        checkOutput("t5_download", 32'(ioctl_download), 0);
        checkOutput("t5_done", 32'(done), 1);
        checkOutput("t5_wr", 32'(ioctl_wr), 0);
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_count", 32'(count), 2);
        checkOutput("t5_s_ready", 32'(s_ready), 1);
        repeat (4) step();
        checkOutput("t5_dl_fall", dlFall, a);
        checkOutput("t5_done_once", doneCount, 1);
        checkOutput("t5_no_more_wr", wrCount, 2);

        // 6: asynchronous reset in mid-transfer, then a fresh transfer
        applyStimulus(5, 8'h55, 1'b0, s);
        loadBytes(5);
        waitWr(1, 100);
        #2;
        reset = 1'b1;
        txQ.delete();
        #1;
        busyExpected = 1'b0;
        checkOutput("t6_download", 32'(ioctl_download), 0);
        checkOutput("t6_wr", 32'(ioctl_wr), 0);
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_count", 32'(count), 0);
        checkOutput("t6_s_ready", 32'(s_ready), 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        checkOutput("t6_no_done", doneCount, 0);
        applyStimulus(3, 8'h66, 1'b0, s);
        loadBytes(3);
        waitDone(200, 1'b0);
        checkOutput("t6_wr_count", wrCount, 3);
        if (wrCycQ.size() > 0) checkOutput("t6_first_wr", wrCycQ[0], s + 1 + SETUP_CYC);
        checkOutput("t6_count_after", 32'(count), 3);

        // Randomized transfers with random pacing and backpressure
        for (int t = 0; t < 6; t++) begin
            len      = $urandom_range(1, 12);
            idx      = 8'($urandom);
            validPct = $urandom_range(30, 100);
            applyStimulus(len, idx, 1'b0, s);
            loadBytes(len + $urandom_range(0, 3));
            waitDone(2000, 1'b1);
            step();
            checkOutput("rnd_wr_count", wrCount, len);
            checkOutput("rnd_count", 32'(count), len);
            checkOutput("rnd_index", 32'(ioctl_index), 32'(idx));
            checkOutput("rnd_idle", 32'(busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
